// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one daisy-chained core bus between two bridges.
// One transaction in flight; returns are matched by address or timed out.
module bus_arbiter #(
    parameter int unsigned TIMEOUT       = 1024,
    parameter int unsigned BASE_ADDR_MIN = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a_addr_i,
    input  logic [15:0] a_data_i,
    input  logic        a_rw_i,
    input  logic        a_valid_i,
    output logic [15:0] a_data_o,
    output logic        a_valid_o,
    output logic        a_err_o,
    output logic        a_busy_o,
    input  logic [15:0] b_addr_i,
    input  logic [15:0] b_data_i,
    input  logic        b_rw_i,
    input  logic        b_valid_i,
    output logic [15:0] b_data_o,
    output logic        b_valid_o,
    output logic        b_err_o,
    output logic        b_busy_o,
    output logic [15:0] bus_addr_o,
    output logic [15:0] bus_data_o,
    output logic        bus_rw_o,
    output logic        bus_valid_o,
    input  logic [15:0] bus_addr_i,
    input  logic [15:0] bus_data_i,
    input  logic        bus_rw_i,
    input  logic        bus_valid_i
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t        state;
    logic [15:0]   a_addr_q;
    logic [15:0]   a_data_q;
    logic          a_rw_q;
    logic [15:0]   b_addr_q;
    logic [15:0]   b_data_q;
    logic          b_rw_q;
    logic          last_b;
    logic          grant_b;
    logic [CW-1:0] cnt;

    logic pick_a;
    logic pick_b;
    logic match;
    logic expire;

    // Base address is informational; tail rw is carried but not needed.
    logic [16:0] cfg_unused;
    assign cfg_unused = {bus_rw_i, 16'(BASE_ADDR_MIN)};

    // Busy flags double as the capture-buffer pending bits.
    assign pick_a = a_busy_o && (!b_busy_o || last_b);
    assign pick_b = b_busy_o && !pick_a;
    assign match  = bus_valid_i && (bus_addr_i == bus_addr_o);
    assign expire = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_addr_q    <= '0;
            a_data_q    <= '0;
            a_rw_q      <= 1'b0;
            b_addr_q    <= '0;
            b_data_q    <= '0;
            b_rw_q      <= 1'b0;
            last_b      <= 1'b1;
            grant_b     <= 1'b0;
            cnt         <= '0;
            a_data_o    <= '0;
            a_valid_o   <= 1'b0;
            a_err_o     <= 1'b0;
            a_busy_o    <= 1'b0;
            b_data_o    <= '0;
            b_valid_o   <= 1'b0;
            b_err_o     <= 1'b0;
            b_busy_o    <= 1'b0;
            bus_addr_o  <= '0;
            bus_data_o  <= '0;
            bus_rw_o    <= 1'b0;
            bus_valid_o <= 1'b0;
        end else begin
            bus_valid_o <= 1'b0;
            a_valid_o   <= 1'b0;
            a_err_o     <= 1'b0;
            b_valid_o   <= 1'b0;
            b_err_o     <= 1'b0;

            if (a_valid_i && !a_busy_o) begin
                a_addr_q <= a_addr_i;
                a_data_q <= a_data_i;
                a_rw_q   <= a_rw_i;
                a_busy_o <= 1'b1;
            end
            if (b_valid_i && !b_busy_o) begin
                b_addr_q <= b_addr_i;
                b_data_q <= b_data_i;
                b_rw_q   <= b_rw_i;
                b_busy_o <= 1'b1;
            end

            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        pick_a: begin
                            bus_addr_o  <= a_addr_q;
                            bus_data_o  <= a_data_q;
                            bus_rw_o    <= a_rw_q;
                            bus_valid_o <= 1'b1;
                            grant_b     <= 1'b0;
                            cnt         <= '0;
                            state       <= WAIT;
                        end
                        pick_b: begin
                            bus_addr_o  <= b_addr_q;
                            bus_data_o  <= b_data_q;
                            bus_rw_o    <= b_rw_q;
                            bus_valid_o <= 1'b1;
                            grant_b     <= 1'b1;
                            cnt         <= '0;
                            state       <= WAIT;
                        end
                        default: ;
                    endcase
                end
                WAIT: begin
                    // A return in the expiry cycle still completes cleanly.
                    if (match || expire) begin
                        if (grant_b) begin
                            b_data_o  <= match ? bus_data_i : 16'h0000;
                            b_valid_o <= 1'b1;
                            b_err_o   <= !match;
                            b_busy_o  <= 1'b0;
                            last_b    <= 1'b1;
                        end else begin
                            a_data_o  <= match ? bus_data_i : 16'h0000;
                            a_valid_o <= 1'b1;
                            a_err_o   <= !match;
                            a_busy_o  <= 1'b0;
                            last_b    <= 1'b0;
                        end
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter with a behavioural daisy-chain model.
// Chain returns each issued transaction four cycles after seeing the strobe.
module tb_bus_arbiter;

    localparam int LAT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] a_addr_i = '0, a_data_i = '0;
    logic        a_rw_i = 1'b0, a_valid_i = 1'b0;
    logic [15:0] b_addr_i = '0, b_data_i = '0;
    logic        b_rw_i = 1'b0, b_valid_i = 1'b0;
    logic [15:0] a_data_o, b_data_o;
    logic        a_valid_o, a_err_o, a_busy_o;
    logic        b_valid_o, b_err_o, b_busy_o;
    logic [15:0] bus_addr_o, bus_data_o;
    logic        bus_rw_o, bus_valid_o;
    logic [15:0] bus_addr_i = '0, bus_data_i = '0;
    logic        bus_rw_i = 1'b0, bus_valid_i = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    bus_arbiter #(.TIMEOUT(16), .BASE_ADDR_MIN(0)) dut (
        .clk(clk), .rst(rst),
        .a_addr_i(a_addr_i), .a_data_i(a_data_i), .a_rw_i(a_rw_i),
        .a_valid_i(a_valid_i), .a_data_o(a_data_o), .a_valid_o(a_valid_o),
        .a_err_o(a_err_o), .a_busy_o(a_busy_o),
        .b_addr_i(b_addr_i), .b_data_i(b_data_i), .b_rw_i(b_rw_i),
        .b_valid_i(b_valid_i), .b_data_o(b_data_o), .b_valid_o(b_valid_o),
        .b_err_o(b_err_o), .b_busy_o(b_busy_o),
        .bus_addr_o(bus_addr_o), .bus_data_o(bus_data_o),
        .bus_rw_o(bus_rw_o), .bus_valid_o(bus_valid_o),
        .bus_addr_i(bus_addr_i), .bus_data_i(bus_data_i),
        .bus_rw_i(bus_rw_i), .bus_valid_i(bus_valid_i)
    );

    always #5 clk = ~clk;

    // Chain model state (written only by the chain process)
    logic [15:0] mem [16];
    bit          wr [16] = '{default: 1'b0};
    int          ret_cnt = 0;
    logic [15:0] ret_addr = '0, ret_data = '0;
    logic        ret_rw = 1'b0;
    int          inject_done = 0;
    int          issue_cnt = 0;
    // Controls written only by the main sequence
    bit          chain_en = 1'b1;
    int          inject_seq = 0;
    logic [15:0] inject_addr = '0;

    function automatic logic [15:0] rom(input logic [3:0] a);
        case (a)
            4'd1:    return 16'h1111;
            4'd3:    return 16'hBEEF;
            4'd6:    return 16'h6666;
            4'd8:    return 16'h8888;
            default: return 16'h0000;
        endcase
    endfunction

    always @(negedge clk) begin
        bus_valid_i = 1'b0;
        if (ret_cnt > 0) begin
            ret_cnt = ret_cnt - 1;
            if (ret_cnt == 0 && chain_en) begin
                bus_valid_i = 1'b1;
                bus_addr_i  = ret_addr;
                bus_data_i  = ret_data;
                bus_rw_i    = ret_rw;
            end
        end
        if (inject_seq != inject_done) begin
            inject_done = inject_seq;
            bus_valid_i = 1'b1;
            bus_addr_i  = inject_addr;
            bus_data_i  = 16'hDEAD;
            bus_rw_i    = 1'b0;
        end
        if (bus_valid_o) begin
            issue_cnt = issue_cnt + 1;
            ret_addr  = bus_addr_o;
            ret_rw    = bus_rw_o;
            if (bus_rw_o) begin
                mem[bus_addr_o[3:0]] = bus_data_o;
                wr[bus_addr_o[3:0]]  = 1'b1;
            end
            ret_data = wr[bus_addr_o[3:0]] ? mem[bus_addr_o[3:0]]
                                           : rom(bus_addr_o[3:0]);
            ret_cnt = LAT;
        end
    end

    typedef struct {
        logic        is_b;
        logic [15:0] addr;
        logic [15:0] data;
        logic        rw;
        logic [15:0] exp_data;
        logic        exp_err;
    } vec_t;

    vec_t tv [6];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic req(input logic is_b, input logic [15:0] addr,
                       input logic [15:0] data, input logic rw);
        @(negedge clk);
        if (is_b) begin
            b_addr_i = addr; b_data_i = data; b_rw_i = rw; b_valid_i = 1'b1;
        end else begin
            a_addr_i = addr; a_data_i = data; a_rw_i = rw; a_valid_i = 1'b1;
        end
        @(negedge clk);
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
    endtask

    task automatic req_both();
        @(negedge clk);
        a_addr_i = 16'h0001; a_data_i = '0; a_rw_i = 1'b0; a_valid_i = 1'b1;
        b_addr_i = 16'h0008; b_data_i = '0; b_rw_i = 1'b0; b_valid_i = 1'b1;
        @(negedge clk);
        a_valid_i = 1'b0;
        b_valid_i = 1'b0;
    endtask

    task automatic wait_done(input logic is_b, output logic [15:0] d,
                             output logic e, output logic op,
                             output logic ob, output logic to);
        d = '0; e = 1'b0; op = 1'b0; ob = 1'b0; to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (is_b ? a_valid_o : b_valid_o) op = 1'b1;
            if (is_b ? a_busy_o : b_busy_o) ob = 1'b1;
            if (is_b ? b_valid_o : a_valid_o) begin
                d  = is_b ? b_data_o : a_data_o;
                e  = is_b ? b_err_o : a_err_o;
                to = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_txn(input string tag, input vec_t v);
        logic [15:0] d;
        logic e, op, ob, to;
        req(v.is_b, v.addr, v.data, v.rw);
        @(posedge clk); #1;
        check({tag, " issue"},
              64'({bus_valid_o, bus_rw_o, bus_addr_o, bus_data_o}),
              64'({1'b1, v.rw, v.addr, v.data}));
        wait_done(v.is_b, d, e, op, ob, to);
        check({tag, " timeout"}, 64'(to), 64'(0));
        check({tag, " data"}, 64'(d), 64'(v.exp_data));
        check({tag, " err"}, 64'(e), 64'(v.exp_err));
        check({tag, " other quiet"}, 64'({op, ob}), 64'(0));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, " req outs"},
              64'({a_data_o, a_valid_o, a_err_o, a_busy_o,
                   b_data_o, b_valid_o, b_err_o, b_busy_o}), 64'(0));
        check({tag, " bus outs"},
              64'({bus_addr_o, bus_data_o, bus_rw_o, bus_valid_o}), 64'(0));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] d;
        logic e, op, ob, to, seen;
        int base, n;

        tv[0] = '{1'b0, 16'h0003, 16'h0000, 1'b0, 16'hBEEF, 1'b0};
        tv[1] = '{1'b1, 16'h0002, 16'h0015, 1'b1, 16'h0015, 1'b0};
        tv[2] = '{1'b1, 16'h0002, 16'h0000, 1'b0, 16'h0015, 1'b0};
        tv[3] = '{1'b0, 16'h0005, 16'h1234, 1'b1, 16'h1234, 1'b0};
        tv[4] = '{1'b0, 16'h0005, 16'h0000, 1'b0, 16'h1234, 1'b0};
        tv[5] = '{1'b1, 16'hFFF0, 16'h0000, 1'b0, 16'h0000, 1'b0};

        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;

        for (int i = 0; i < 6; i++)
            run_txn($sformatf("vec%0d", i), tv[i]);

        // Arbitration: A wins the first tie, then alternation
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        req_both();
        @(posedge clk); #1;
        check("arb1 first", 64'({bus_valid_o, bus_addr_o}), 64'({1'b1, 16'h0001}));
        check("arb1 b pending", 64'(b_busy_o), 64'(1));
        wait_done(1'b0, d, e, op, ob, to);
        check("arb1 a done", 64'({to, e, d}), 64'({1'b0, 1'b0, 16'h1111}));
        @(posedge clk); #1;
        check("arb1 second", 64'({bus_valid_o, bus_addr_o}), 64'({1'b1, 16'h0008}));
        wait_done(1'b1, d, e, op, ob, to);
        check("arb1 b done", 64'({to, e, d}), 64'({1'b0, 1'b0, 16'h8888}));
        run_txn("solo a", '{1'b0, 16'h0001, 16'h0000, 1'b0, 16'h1111, 1'b0});
        req_both();
        @(posedge clk); #1;
        check("arb2 first", 64'({bus_valid_o, bus_addr_o}), 64'({1'b1, 16'h0008}));
        wait_done(1'b1, d, e, op, ob, to);
        check("arb2 b done", 64'({to, e, d}), 64'({1'b0, 1'b0, 16'h8888}));
        @(posedge clk); #1;
        check("arb2 second", 64'({bus_valid_o, bus_addr_o}), 64'({1'b1, 16'h0001}));
        wait_done(1'b0, d, e, op, ob, to);
        check("arb2 a done", 64'({to, e, d}), 64'({1'b0, 1'b0, 16'h1111}));

        // Busy drop, including a request in the completion cycle
        base = issue_cnt;
        req(1'b0, 16'h0003, 16'h0000, 1'b0);
        @(posedge clk); #1;
        check("drop issue", 64'({bus_valid_o, bus_addr_o}), 64'({1'b1, 16'h0003}));
        @(negedge clk);
        a_addr_i = 16'h0007; a_valid_i = 1'b1;
        @(negedge clk);
        a_valid_i = 1'b0;
        check("drop busy", 64'(a_busy_o), 64'(1));
        repeat (3) @(negedge clk);
        a_valid_i = 1'b1;
        @(negedge clk);
        check("drop done", 64'({a_valid_o, a_err_o, a_data_o}),
              64'({1'b1, 1'b0, 16'hBEEF}));
        a_valid_i = 1'b0;
        repeat (10) @(negedge clk);
        check("drop issues", 64'(issue_cnt - base), 64'(1));
        check("drop idle", 64'(a_busy_o), 64'(0));

        // Timeout with a dead chain, then a stale return
        chain_en = 1'b0;
        req(1'b0, 16'h0009, 16'h0000, 1'b0);
        @(posedge clk); #1;
        check("to issue", 64'({bus_valid_o, bus_addr_o}), 64'({1'b1, 16'h0009}));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!a_valid_o && n < 40);
        check("to latency", 64'(n), 64'(17));
        check("to result", 64'({a_valid_o, a_err_o, a_data_o}),
              64'({1'b1, 1'b1, 16'h0000}));
        chain_en = 1'b1;
        @(negedge clk);
        inject_addr = 16'h0009;
        inject_seq++;
        seen = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (a_valid_o || b_valid_o) seen = 1'b1;
        end
        check("late return ignored", 64'(seen), 64'(0));
        check("to idle", 64'({a_busy_o, b_busy_o}), 64'(0));
        run_txn("post timeout", '{1'b0, 16'h0003, 16'h0000, 1'b0, 16'hBEEF, 1'b0});

        // Reset while waiting
        req(1'b0, 16'h0004, 16'h0000, 1'b0);
        @(posedge clk); #1;
        check("rst issue", 64'({bus_valid_o, bus_addr_o}), 64'({1'b1, 16'h0004}));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("mid-wait rst");
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (a_valid_o || b_valid_o || a_busy_o) seen = 1'b1;
        end
        check("rst return ignored", 64'(seen), 64'(0));
        run_txn("post rst b", '{1'b1, 16'h0006, 16'h0000, 1'b0, 16'h6666, 1'b0});

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
- Shares the single daisy-chained core bus between two host bridges, requester A and requester B (e.g. UART and Ethernet).
- Issues one transaction at a time onto the chain head and waits for the same transaction to return from the chain tail.
- Routes the returned data back to the requester that issued it.
- Round-robin fairness between A and B; a timeout recovers from a broken chain.

Parameters:
- TIMEOUT, 1024: cycles spent in WAIT without a matching return before an error completion.
- BASE_ADDR_MIN, 0: lowest address accepted from requesters. Requests below it are still forwarded; the parameter is informational only and exposed for the integration check.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- a_addr_i  in  16  requester A address
- a_data_i  in  16  requester A write data
- a_rw_i  in  1  requester A: 1 = write, 0 = read
- a_valid_i  in  1  requester A request strobe, single cycle
- a_data_o  out  16  data returned to A
- a_valid_o  out  1  completion pulse to A
- a_err_o  out  1  timeout flag, coincident with a_valid_o
- a_busy_o  out  1  A request pending or in flight
- b_addr_i, b_data_i, b_rw_i, b_valid_i, b_data_o, b_valid_o, b_err_o, b_busy_o: identical for requester B
- bus_addr_o  out  16  chain head address
- bus_data_o  out  16  chain head data
- bus_rw_o  out  1  chain head read/write
- bus_valid_o  out  1  chain head strobe
- bus_addr_i  in  16  chain tail address
- bus_data_i  in  16  chain tail data
- bus_rw_i  in  1  chain tail read/write
- bus_valid_i  in  1  chain tail strobe

Behaviour:
- Reset (async, rst=1): all outputs and internal registers are 0, state is IDLE, last_grant = B so A wins the first tie.
- All outputs are registered.
- Capture buffers: one per requester (addr, data, rw, pend).
  - x_valid_i with pend_x=0 loads the buffer and sets pend_x at that edge.
  - x_valid_i with pend_x=1 is dropped silently, including in the cycle the completion clears pend_x.
  - x_busy_o = pend_x.
- FSM states: IDLE, WAIT.
- IDLE:
  - If only one pend is set, grant that requester.
  - If both are set, grant the requester opposite last_grant.
  - At the grant edge: drive bus_* from the granted buffer with bus_valid_o=1 for exactly one cycle, record grant, clear the timeout counter, go to WAIT.
  - A request captured at edge N while in IDLE appears on the bus in the cycle after edge N+1.
- WAIT:
  - bus_valid_o=0.
  - On bus_valid_i=1 with bus_addr_i equal to the issued address: x_data_o<=bus_data_i and x_valid_o<=1 for one cycle, x_err_o=0. Clear pend_x, set last_grant=x, go to IDLE.
  - Completion pulses for both reads and writes; for writes, data_o is the returned data.
  - bus_valid_i with a mismatched address is ignored.
  - The counter increments each WAIT cycle. At counter == TIMEOUT-1 with no match: x_data_o<=0, x_valid_o<=1, x_err_o<=1, clear pend_x, update last_grant, go to IDLE.
  - If a match and the timeout occur in the same cycle, the match wins (err=0).
- Counter width is $clog2(TIMEOUT+1); it never wraps.
- bus_valid_i while in IDLE is ignored, e.g. a stale return after reset or after a timeout.
- Reset mid-WAIT aborts the transaction with no completion pulse; a later return is ignored.
- Only one transaction is outstanding at any time.
- The next grant can occur at the edge after a completion.

Test Plan:
- Single A read: bench chain model returns 0xBEEF for addr 0x0003 after 4 cycles; a_valid_i with addr 3, rw 0 -> bus_valid_o one cycle later, a_valid_o pulses with a_data_o=0xBEEF and a_err_o=0; b_* stay 0.
- B write then read via an io_core-backed chain (BASE_ADDR 0): write 0x0015 to addr 0x0002, then read addr 0x0002 -> b_valid_o pulses twice, second b_data_o=0x0015; a_busy_o=0 throughout.
- Simultaneous A and B requests after reset -> A issued first, B issued at the edge after A completes; repeat with both pending -> B first, confirming alternation.
- Busy drop: assert a_valid_i twice while a_busy_o=1 -> exactly one bus_valid_o for A; the second request is never issued.
- Timeout: TIMEOUT=16, chain model never returns -> after 16 WAIT cycles a_valid_o=1, a_err_o=1, a_data_o=0x0000; a late bus_valid_i for that address produces no pulse.
- Reset mid-WAIT: rst pulse after issue -> all outputs 0 immediately; the returning bus_valid_i is ignored; a subsequent B request completes normally.
